// File: rtl/spi_cmd_ctrl_pkg.sv
// spi_cmd_ctrl_pkg: shared word width, opcodes, register indices, error bits and FSM states.
package spi_cmd_ctrl_pkg;
   localparam int SPI_WIDHT = 16;
   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_REG_WR = 2'b01;
   localparam logic [1:0] OP_REG_RD = 2'b10;
   localparam logic [1:0] OP_BURST  = 2'b11;
   localparam logic [2:0] REG_MEM_BASE = 3'd1;
   localparam logic [2:0] REG_STATUS   = 3'd7;
   localparam int ERR_UNDERRUN = 0;
   localparam int ERR_ABORT    = 1;
   typedef enum logic [1:0] {IDLE, WR_DATA, BURST, DRAIN} state_t;
endpackage

// File: rtl/spi_ss_sync.sv
// spi_ss_sync: two-flop synchroniser for the asynchronous SPI chip select plus rising-edge pulse.
//   clk, rst_n : system clock, asynchronous active-low reset
//   ss_n       : raw chip select
//   rise       : one-cycle pulse when the synchronised chip select goes high
module spi_ss_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic ss_n,
   output logic rise
);
   logic [2:0] sync;
   // Preset to deselected so reset release never looks like a rising edge.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync <= '1;
      else sync <= {sync[1:0], ss_n};
   assign rise = sync[1] & ~sync[2];
endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes SPI host words into register writes/reads and frame-buffer burst reads.
//   clkIN, nResetIN         : system clock, asynchronous active-low reset
//   nSSIN                   : raw chip select; a rise aborts WR_DATA/BURST
//   wordValidIN, wordIN     : received-word strobe and data from the SPI slave
//   wordOUT                 : next word the slave shifts out
//   memRdReqOUT/AddrOUT     : frame-buffer read request and address
//   memRdAckIN, memDataIN   : read completion and data
//   cfgOUT                  : registers 0..6, register n at [16n+15:16n]
//   busyOUT, errOUT         : not-idle flag, sticky {abort, underrun} flags
module spi_cmd_ctrl
   import spi_cmd_ctrl_pkg::*;
#(
   parameter int SPI_WIDTH  = SPI_WIDHT,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                   clkIN,
   input  logic                   nResetIN,
   input  logic                   nSSIN,
   input  logic                   wordValidIN,
   input  logic [SPI_WIDTH-1:0]   wordIN,
   output logic [SPI_WIDTH-1:0]   wordOUT,
   output logic                   memRdReqOUT,
   output logic [ADDR_WIDTH-1:0]  memAddrOUT,
   input  logic                   memRdAckIN,
   input  logic [SPI_WIDTH-1:0]   memDataIN,
   output logic [7*SPI_WIDTH-1:0] cfgOUT,
   output logic                   busyOUT,
   output logic [1:0]             errOUT
);
   state_t state, next;
   logic [6:0][SPI_WIDTH-1:0] cfg;
   logic [2:0] idx, cmd_idx;
   logic [1:0] op;
   logic [10:0] len;
   logic [11:0] rem, rem_dec;
   logic ready, pend, ss_rise, abort, outstanding, last;
   logic [SPI_WIDTH-1:0] rd_val;

   spi_ss_sync u_ss (.clk(clkIN), .rst_n(nResetIN), .ss_n(nSSIN), .rise(ss_rise));

   assign op          = wordIN[15:14];
   assign cmd_idx     = wordIN[13:11];
   assign len         = wordIN[10:0];
   assign rem_dec     = rem - 12'd1;
   assign last        = rem == 12'd1;
   assign outstanding = memRdReqOUT & ~memRdAckIN;
   assign abort       = ss_rise & (state == WR_DATA || state == BURST);
   assign rd_val      = cmd_idx == REG_STATUS ? SPI_WIDTH'(errOUT) : cfg[cmd_idx];
   assign cfgOUT      = cfg;

   always_ff @(posedge clkIN or negedge nResetIN)
      if (!nResetIN) begin
         state   <= IDLE;
         busyOUT <= 1'b0;
      end else begin
         state   <= next;
         busyOUT <= next != IDLE;
      end

   // A read still in flight must complete in DRAIN so the request is never withdrawn early.
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (wordValidIN) next = op == OP_REG_WR ? WR_DATA : op == OP_BURST ? BURST : IDLE;
         WR_DATA: if (abort || wordValidIN) next = IDLE;
         BURST:   if (abort || (wordValidIN && last)) next = outstanding ? DRAIN : IDLE;
         DRAIN:   if (memRdAckIN) next = IDLE;
      endcase
   end

   always_ff @(posedge clkIN or negedge nResetIN)
      if (!nResetIN) begin
         cfg         <= '0;
         idx         <= '0;
         rem         <= '0;
         ready       <= 1'b0;
         pend        <= 1'b0;
         wordOUT     <= '0;
         memRdReqOUT <= 1'b0;
         memAddrOUT  <= '0;
         errOUT      <= '0;
      end else begin
         if (memRdAckIN) memRdReqOUT <= 1'b0;
         case (state)
            IDLE: if (wordValidIN) begin
               idx <= cmd_idx;
               case (op)
                  OP_NOP, OP_REG_WR: wordOUT <= '0;
                  OP_REG_RD: wordOUT <= rd_val;
                  OP_BURST: begin
                     rem         <= {~|len, len};
                     memAddrOUT  <= ADDR_WIDTH'(cfg[REG_MEM_BASE]);
                     memRdReqOUT <= 1'b1;
                     ready       <= 1'b0;
                     pend        <= 1'b0;
                  end
               endcase
            end
            WR_DATA:
               if (abort) errOUT[ERR_ABORT] <= 1'b1;
               else if (wordValidIN) begin
                  wordOUT <= '0;
                  if (idx == REG_STATUS) errOUT <= errOUT & ~wordIN[1:0];
                  else cfg[idx] <= wordIN;
               end
            BURST:
               if (abort) begin
                  errOUT[ERR_ABORT] <= 1'b1;
                  pend              <= 1'b0;
                  ready             <= 1'b0;
               end else begin
                  // pend: a read was owed while the previous one was being acked; issue it now,
                  // which leaves the mandatory idle cycle between requests.
                  if (pend) begin
                     memRdReqOUT <= ~(wordValidIN & last);
                     pend        <= 1'b0;
                  end
                  if (memRdAckIN) begin
                     memAddrOUT <= memAddrOUT + ADDR_WIDTH'(1);
                     if (!(wordValidIN && !ready)) begin
                        wordOUT <= memDataIN;
                        ready   <= 1'b1;
                     end
                  end
                  if (wordValidIN) begin
                     rem   <= rem_dec;
                     ready <= 1'b0;
                     if (!ready) errOUT[ERR_UNDERRUN] <= 1'b1;
                     if (last) wordOUT <= '0;
                     else if (!memRdReqOUT) memRdReqOUT <= 1'b1;
                     else if (memRdAckIN) pend <= 1'b1;
                  end
               end
            DRAIN: ;
         endcase
      end
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: self-checking bench for spi_cmd_ctrl with a memory responder and a register-file model.
module tb_spi_cmd_ctrl;
   logic clk = 1'b0, rst_n = 1'b0, ss_n = 1'b1, valid = 1'b0, ack = 1'b0;
   logic [15:0] wdata = '0, mdata = '0;
   logic [15:0] word_out, addr;
   logic req, busy;
   logic [1:0] err;
   logic [111:0] cfg;
   int n_chk = 0, n_fail = 0, lat = 2, ack_cnt = 0;
   logic [15:0] addr_q [$];
   logic [15:0] m_reg [8];
   logic [1:0] m_err;

   typedef struct { logic [2:0] idx; logic [15:0] wr; logic [15:0] exp; } vec_t;
   vec_t tbl [7];

   spi_cmd_ctrl dut (
      .clkIN(clk), .nResetIN(rst_n), .nSSIN(ss_n), .wordValidIN(valid), .wordIN(wdata),
      .wordOUT(word_out), .memRdReqOUT(req), .memAddrOUT(addr), .memRdAckIN(ack),
      .memDataIN(mdata), .cfgOUT(cfg), .busyOUT(busy), .errOUT(err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mf(input logic [15:0] a);
      return (a * 16'd3) ^ 16'h5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [15:0] w);
      repeat (4) @(negedge clk);
      valid = 1'b1;
      wdata = w;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic wait_ack(input int target);
      int k = 0;
      while (ack_cnt < target && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("ack_arrived", ack_cnt >= target, 1);
   endtask

   // Memory: acks after lat cycles, logs addresses, checks the request handshake.
   initial begin : mem
      logic pr;
      logic [15:0] paddr;
      int cnt;
      pr = 1'b0;
      paddr = '0;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (ack) chk("req_drop_after_ack", req, 0);
         if (pr && req && !ack) chk("addr_stable", addr, paddr);
         pr = req;
         paddr = addr;
         if (ack) ack = 1'b0;
         else if (req) begin
            if (cnt >= lat) begin
               ack = 1'b1;
               mdata = mf(addr);
               addr_q.push_back(addr);
               ack_cnt++;
               cnt = 0;
            end else cnt++;
         end else cnt = 0;
      end
   end

   task automatic do_burst(input logic [15:0] base, input int n, input int l);
      int b;
      lat = l;
      addr_q.delete();
      b = ack_cnt;
      send({2'b11, 3'($urandom_range(0, 7)), 11'(n)});
      for (int i = 0; i < n; i++) begin
         wait_ack(b + i + 1);
         @(negedge clk);
         if (addr_q.size() > 0) chk("burst_addr", addr_q.pop_front(), base + 16'(i));
         else chk("burst_addr_missing", 0, 1);
         chk("burst_word", word_out, mf(base + 16'(i)));
         chk("burst_busy", busy, 1);
         send(16'($urandom));
      end
      chk("burst_end_word", word_out, 0);
      chk("burst_end_busy", busy, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_err = '0;
      tbl[0] = '{3'd0, 16'h1234, 16'h1234};
      tbl[1] = '{3'd2, 16'hFFFF, 16'hFFFF};
      tbl[2] = '{3'd3, 16'h0000, 16'h0000};
      tbl[3] = '{3'd4, 16'hA5A5, 16'hA5A5};
      tbl[4] = '{3'd5, 16'h8001, 16'h8001};
      tbl[5] = '{3'd6, 16'h7FFE, 16'h7FFE};
      tbl[6] = '{3'd7, 16'hFFFF, 16'h0000};

      repeat (3) @(negedge clk);
      chk("rst_word", word_out, 0);
      chk("rst_req", req, 0);
      chk("rst_addr", addr, 0);
      chk("rst_cfg", cfg == 112'd0, 1);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      ss_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      send(16'h4800);
      send(16'h1234);
      chk("wr_cfg1", cfg[31:16], 16'h1234);
      chk("wr_err", err, 0);
      send(16'h8800);
      chk("rd_word", word_out, 16'h1234);
      chk("rd_idle", busy, 0);

      foreach (tbl[i]) begin
         send({2'b01, tbl[i].idx, 11'h0});
         chk("tbl_busy_wr", busy, 1);
         send(tbl[i].wr);
         chk("tbl_wr_word", word_out, 0);
         if (tbl[i].idx != 3'd7) chk("tbl_cfg", cfg[16*tbl[i].idx +: 16], tbl[i].exp);
         send({2'b10, tbl[i].idx, 11'h0});
         chk("tbl_rd", word_out, tbl[i].exp);
      end

      send(16'h4800);
      send(16'h0100);
      do_burst(16'h0100, 3, 2);
      chk("burst_err", err, 0);

      lat = 20;
      b = ack_cnt;
      send(16'h8800);
      chk("ur_pre", word_out, 16'h0100);
      send(16'hC002);
      send(16'h1111);
      chk("ur_err", err, 2'b01);
      chk("ur_word_kept", word_out, 16'h0100);
      chk("ur_busy", busy, 1);
      wait_ack(b + 1);
      @(negedge clk);
      chk("ur_late_word", word_out, mf(16'h0100));
      send(16'h2222);
      chk("ur_end_busy", busy, 0);
      chk("ur_end_word", word_out, 0);
      chk("ur_one_read", ack_cnt, b + 1);
      send(16'h7800);
      send(16'h0001);
      chk("ur_clear", err, 0);

      b = ack_cnt;
      send(16'hC004);
      repeat (3) @(negedge clk);
      ss_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("ab_drain_busy", busy, 1);
      chk("ab_req_held", req, 1);
      chk("ab_err", err, 2'b10);
      wait_ack(b + 1);
      @(negedge clk);
      chk("ab_idle", busy, 0);
      repeat (10) @(negedge clk);
      chk("ab_no_req", req, 0);
      chk("ab_acks", ack_cnt, b + 1);
      ss_n = 1'b0;
      repeat (4) @(negedge clk);

      send(16'h7800);
      send(16'h0003);
      chk("clr_all", err, 0);
      ss_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_rise_no_err", err, 0);
      ss_n = 1'b0;
      repeat (4) @(negedge clk);
      send(16'h4000);
      ss_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("wr_abort_err", err, 2'b10);
      chk("wr_abort_idle", busy, 0);
      ss_n = 1'b0;
      repeat (4) @(negedge clk);
      send(16'h0000);
      chk("wr_abort_cfg0", cfg[15:0], 16'h1234);

      send(16'h8800);
      chk("rst_pre_word", word_out, 16'h0100);
      lat = 20;
      send(16'hC005);
      repeat (3) @(negedge clk);
      chk("rst_pre_req", req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_req", req, 0);
      chk("rst_mid_word", word_out, 0);
      chk("rst_mid_cfg", cfg == 112'd0, 1);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_err", err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int t = 0; t < 40; t++) begin
         logic [2:0] ri;
         logic [15:0] rd;
         int ro;
         ro = $urandom_range(0, 3);
         ri = 3'($urandom_range(0, 7));
         rd = 16'($urandom);
         if (ri == 3'd1 && rd[0]) rd = 16'hFFFE;
         case (ro)
            0: begin
               send({2'b00, 14'($urandom)});
               chk("rnd_nop", word_out, 0);
            end
            1: begin
               send({2'b01, ri, 11'($urandom)});
               send(rd);
               if (ri == 3'd7) m_err &= ~rd[1:0];
               else m_reg[ri] = rd;
               chk("rnd_wr_word", word_out, 0);
               chk("rnd_wr_err", err, m_err);
               if (ri != 3'd7) chk("rnd_wr_cfg", cfg[16*ri +: 16], m_reg[ri]);
            end
            2: begin
               send({2'b10, ri, 11'($urandom)});
               chk("rnd_rd", word_out, ri == 3'd7 ? {14'b0, m_err} : m_reg[ri]);
            end
            default: do_burst(m_reg[1], $urandom_range(1, 4), $urandom_range(0, 6));
         endcase
         chk("rnd_busy", busy, 0);
      end

      do_burst(m_reg[1], 2048, 0);
      chk("long_burst_err", err, m_err);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
